// File: rtl/pass_detector.sv
// pass_detector
//   Generates the one-cycle `add` strobe for the score digit chain. The pipe
//   column is tracked against the fixed bird column, and a point is credited
//   once per pipe, when the pipe's span has moved entirely left of the bird.
//   Credited points are queued and issued as pulses spaced GAP idle cycles
//   apart, so that carries in the digit chain settle between increments.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous reset, active low
//   start     in   game running; low forces IDLE and flushes the queue
//   collide   in   bird hit pipe/ground this cycle
//   pipe_col  in   leftmost column of the current pipe [COL_W-1:0]
//   add       out  one-cycle point strobe (registered)
//   overlap   out  bird column inside the pipe span (state OVERLAP)
//   dead      out  state DEAD
//   lost      out  sticky: a point was dropped because the queue was full
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | game not running, queue empty
// APPROACH | pipe still right of the bird, not yet scored
// OVERLAP  | bird column inside the pipe span, not yet scored
// CLEAR    | pipe already scored, waiting for the next pipe to respawn
// DEAD     | collision seen; queued points still drain
module pass_detector #(
    parameter int COL_W    = 4,
    parameter int BIRD_COL = 3,
    parameter int PIPE_W   = 2,
    parameter int GAP      = 2,
    parameter int PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             collide,
    input  logic [COL_W-1:0] pipe_col,
    output logic             add,
    output logic             overlap,
    output logic             dead,
    output logic             lost
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [COL_W:0] LO    = (COL_W+1)'(BIRD_COL - PIPE_W + 1);
    localparam logic [COL_W:0] HI    = (COL_W+1)'(BIRD_COL);
    localparam logic [PW-1:0]  PMAX  = PW'(PEND_MAX);
    localparam logic [GW-1:0]  GAP_V = GW'(GAP);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        APPROACH = 3'd1,
        OVERLAP  = 3'd2,
        CLEAR    = 3'd3,
        DEAD     = 3'd4
    } state_t;

    state_t         state;
    logic [PW-1:0]  pending;
    logic [GW-1:0]  gap_cnt;

    logic [COL_W:0] col;
    logic           below;
    logic           above;
    logic           in_span;
    logic           armed;
    logic           pt;
    logic           issue;
    logic [PW:0]    pend_sum;
    logic [PW:0]    pend_dec;

    // Extra top bit keeps every column compare unsigned and overflow free.
    assign col      = {1'b0, pipe_col};
    assign below    = (col < LO);
    assign above    = (col > HI);
    assign in_span  = !below && !above;
    assign armed    = (state == APPROACH) || (state == OVERLAP);

    // A pass in the same cycle as a collision earns nothing.
    assign pt       = armed && below && !collide;
    assign issue    = (gap_cnt == '0) && ((pending != '0) || pt);
    assign pend_sum = {1'b0, pending} + {{PW{1'b0}}, pt};
    assign pend_dec = pend_sum - 1'b1;

    assign overlap  = (state == OVERLAP);
    assign dead     = (state == DEAD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            gap_cnt <= '0;
            add     <= 1'b0;
            lost    <= 1'b0;
        end else if (!start) begin
            // lost stays sticky across games; only reset clears it.
            state   <= IDLE;
            pending <= '0;
            gap_cnt <= '0;
            add     <= 1'b0;
        end else begin
            case (state)
                IDLE:     state <= APPROACH;
                APPROACH: begin
                    if (collide)      state <= DEAD;
                    else if (below)   state <= CLEAR;
                    else if (in_span) state <= OVERLAP;
                end
                OVERLAP: begin
                    if (collide)      state <= DEAD;
                    else if (below)   state <= CLEAR;
                    else if (above)   state <= APPROACH;
                end
                CLEAR: begin
                    if (collide)      state <= DEAD;
                    else if (above)   state <= APPROACH;
                end
                DEAD:     state <= DEAD;
                default:  state <= IDLE;
            endcase

            if (issue) begin
                // Issuing consumes one point; a new point this cycle can
                // only refill what was taken, so no saturation is needed.
                add     <= 1'b1;
                pending <= pend_dec[PW-1:0];
                gap_cnt <= GAP_V;
            end else begin
                add <= 1'b0;
                if (gap_cnt != '0)
                    gap_cnt <= gap_cnt - 1'b1;
                if (pend_sum > {1'b0, PMAX})
                    pending <= PMAX;
                else
                    pending <= pend_sum[PW-1:0];
                if ((pending == PMAX) && pt)
                    lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pass_detector.sv
// tb_pass_detector
//   Directed scenarios followed by randomized play, all checked cycle by cycle
//   against a behavioural model of the game rules (pipe credited once, queue
//   of owed points, minimum spacing between issued pulses).
module tb_pass_detector;

    localparam int COL_W    = 4;
    localparam int BIRD_COL = 3;
    localparam int PIPE_W   = 2;
    localparam int GAP      = 2;
    localparam int PEND_MAX = 3;
    localparam int LO_COL   = BIRD_COL - PIPE_W + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic             collide;
    logic [COL_W-1:0] pipe_col;
    logic             add;
    logic             overlap;
    logic             dead;
    logic             lost;

    pass_detector #(
        .COL_W   (COL_W),
        .BIRD_COL(BIRD_COL),
        .PIPE_W  (PIPE_W),
        .GAP     (GAP),
        .PEND_MAX(PEND_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .collide (collide),
        .pipe_col(pipe_col),
        .add     (add),
        .overlap (overlap),
        .dead    (dead),
        .lost    (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_adds   = 0;
    int cyc      = 0;

    // Behavioural model: game flags, owed points, time of last pulse.
    bit m_running   = 0;
    bit m_alive     = 1;
    bit m_scorable  = 1;
    bit m_in_span   = 0;
    int m_owed      = 0;
    int m_last_add  = -1000;
    bit m_add       = 0;
    bit m_lost      = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit c, input int col);
        bit pass_now;
        bit left_of_bird;
        bit right_of_bird;
        left_of_bird  = (col < LO_COL);
        right_of_bird = (col > BIRD_COL);
        if (!r || !s) begin
            m_running  = 0;
            m_owed     = 0;
            m_last_add = -1000;
            m_add      = 0;
            if (!r) m_lost = 0;
            return;
        end
        pass_now = m_running && m_alive && m_scorable && left_of_bird && !c;
        if (!m_running) begin
            m_running  = 1;
            m_alive    = 1;
            m_scorable = 1;
            m_in_span  = 0;
        end else if (!m_alive) begin
        end else if (c) begin
            m_alive = 0;
        end else if (m_scorable) begin
            if (left_of_bird) begin
                m_scorable = 0;
                m_in_span  = 0;
            end else begin
                m_in_span = !right_of_bird;
            end
        end else if (right_of_bird) begin
            m_scorable = 1;
            m_in_span  = 0;
        end
        if ((cyc - m_last_add) > GAP && (m_owed > 0 || pass_now)) begin
            m_add      = 1;
            m_owed     = m_owed + int'(pass_now) - 1;
            m_last_add = cyc;
        end else begin
            m_add = 0;
            if (m_owed == PEND_MAX && pass_now) m_lost = 1;
            m_owed = m_owed + int'(pass_now);
            if (m_owed > PEND_MAX) m_owed = PEND_MAX;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c, input int col);
        @(negedge clk);
        reset    = r;
        start    = s;
        collide  = c;
        pipe_col = COL_W'(col);
        @(posedge clk);
        cyc++;
        model_edge(r, s, c, col);
        #1;
        if (add) n_adds++;
        chk("add",     int'(add),         int'(m_add));
        chk("overlap", int'(overlap),     int'(m_running && m_alive && m_scorable && m_in_span));
        chk("dead",    int'(dead),        int'(m_running && !m_alive));
        chk("lost",    int'(lost),        int'(m_lost));
        chk("pending", int'(dut.pending), m_owed);
    endtask

    initial begin
        int col;
        int base;
        reset    = 1'b0;
        start    = 1'b0;
        collide  = 1'b0;
        pipe_col = '0;

        // Reset, then start with the pipe far right.
        step(0, 0, 0, 15);
        step(0, 0, 0, 15);
        step(1, 1, 0, 15);
        chk("t1_add", int'(add), 0);
        chk("t1_lost", int'(lost), 0);

        // One full scroll: a single point when the pipe clears the bird.
        base = n_adds;
        for (int c = 15; c >= 0; c--)
            for (int k = 0; k < 4; k++) step(1, 1, 0, c);
        chk("t2_adds", n_adds - base, 1);

        // Respawn and a second pass.
        for (int k = 0; k < 4; k++) step(1, 1, 0, 15);
        for (int c = 14; c >= 0; c--)
            for (int k = 0; k < 2; k++) step(1, 1, 0, c);
        chk("t3_score", n_adds - base, 2);

        // Pass coincident with a collision scores nothing.
        step(1, 1, 0, 15);
        step(1, 1, 0, 5);
        step(1, 1, 0, 3);
        base = n_adds;
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        chk("t4_noadd", n_adds - base, 0);
        chk("t4_dead", int'(dead), 1);
        step(1, 0, 0, 15);
        chk("t4_idle", int'(dead), 0);

        // Rapid points: pulses must stay GAP cycles apart and drain fully.
        step(1, 1, 0, 15);
        base = n_adds;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 15);
            step(1, 1, 0, 0);
        end
        for (int k = 0; k < 12; k++) step(1, 1, 0, 0);
        chk("t5_adds", n_adds - base, 3);
        chk("t5_pending", int'(dut.pending), 0);

        // Overfill the queue, then reset mid-queue.
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, 15);
            step(1, 1, 0, 0);
        end
        chk("t6_lost", int'(lost), 1);
        step(0, 1, 0, 15);
        chk("t6_add", int'(add), 0);
        chk("t6_pending", int'(dut.pending), 0);
        chk("t6_lost_rst", int'(lost), 0);

        // Randomized play.
        col = 15;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)      col = (col == 0) ? 15 : col - 1;
            else if (r < 75) col = col;
            else if (r < 90) col = int'($urandom_range(0, 15));
            else             col = 15;
            step($urandom_range(0, 499) != 0,
                 $urandom_range(0, 149) != 0,
                 $urandom_range(0, 59) == 0,
                 col);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
